// File: rtl/handshake_fifo_buffer.sv
// ---------------------------------------------------------------------------
// handshake_fifo_buffer
//
// Elastic FIFO on a valid/ready dataflow channel. It decouples a producer
// (constant/operator stage) from its consumer, absorbs back-pressure and
// breaks the combinational valid/ready path between them.
//
// Default build (opaque): the output comes from storage, so a word accepted
// on edge N appears on outs after that edge. ins_ready depends only on the
// occupancy, never on outs_ready.
//
// Optional feature, macro HANDSHAKE_FIFO_BYPASS_EN (transparent mode):
// when the buffer is empty, an incoming word is presented on outs in the
// same cycle. If the consumer takes it, nothing is stored. Otherwise it is
// stored as a normal push.
//
// Parameters:
//   DATA_WIDTH  payload width in bits (>= 1)
//   NUM_SLOTS   storage depth in entries (>= 2, any value, not only 2^n)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset, empties the buffer
//   ins         input payload
//   ins_valid   producer has a word on ins
//   ins_ready   buffer can accept a word (not full)
//   outs        output payload, all-zero when nothing is presented
//   outs_valid  buffer presents a word on outs
//   outs_ready  consumer takes the presented word
// ---------------------------------------------------------------------------
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  // Payload storage; it has no reset because occupancy is tracked by count.
  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  pass_through;
  logic [DATA_WIDTH-1:0] head_data;

  // Pointers wrap explicitly at NUM_SLOTS-1, so any depth works, not only
  // powers of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign ins_ready = !full;
  assign head_data = empty ? '0 : mem[head];

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // An empty buffer forwards the producer's word directly. If the consumer
  // takes it in the same cycle, the word never touches storage.
  assign pass_through = empty & ins_valid & outs_ready;
  assign outs_valid   = !empty | ins_valid;
  assign outs         = empty ? (ins_valid ? ins : '0) : head_data;
`else
  assign pass_through = 1'b0;
  assign outs_valid   = !empty;
  assign outs         = head_data;
`endif

  // A pop can only drain a stored word. A forwarded word is accounted
  // for by pass_through, which also suppresses the push.
  assign push = ins_valid & ins_ready & !pass_through;
  assign pop  = !empty & outs_ready;

  // The memory write port has no reset. Stale contents are harmless
  // because count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= ins;
    end
  end

  // Pointer and occupancy bookkeeping. Push on full and pop on empty are
  // impossible by construction, so count cannot overflow or underflow.
  // A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= next_ptr(tail);
      end
      if (pop) begin
        head <= next_ptr(head);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_handshake_fifo_buffer
//
// Self-checking bench for handshake_fifo_buffer. There are two instances:
// the default 4-slot buffer and a 3-slot buffer, which exercises
// non-power-of-two pointer wrap. A reference model predicts the outputs.
// It keeps a scoreboard queue of accepted words and an occupancy count per
// instance. Every accepted word is pushed to the queue. Every word the
// consumer takes is popped from the queue and compared.
// ---------------------------------------------------------------------------
module tb_handshake_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] ins0, outs0, ins1, outs1;
  logic        ins_valid0, ins_ready0, outs_valid0, outs_ready0;
  logic        ins_valid1, ins_ready1, outs_valid1, outs_ready1;

  int          test_count = 0;
  int          fail_count = 0;

  // Reference model state, index 0 = 4-slot DUT, index 1 = 3-slot DUT.
  int          exp_cnt [2];
  int          popped  [2];
  int          slots   [2];
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  // Random phase state.
  logic [31:0] next_word;
  logic        pend;
  logic        rv, rr, accepted;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins0),
    .ins_valid  (ins_valid0),
    .ins_ready  (ins_ready0),
    .outs       (outs0),
    .outs_valid (outs_valid0),
    .outs_ready (outs_ready0)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins1),
    .ins_valid  (ins_valid1),
    .ins_ready  (ins_ready1),
    .outs       (outs1),
    .outs_valid (outs_valid1),
    .outs_ready (outs_ready1)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic v,
                               input logic [31:0] d, input logic r);
    if (sel == 0) begin
      ins_valid0 = v; ins0 = d; outs_ready0 = r;
    end else begin
      ins_valid1 = v; ins1 = d; outs_ready1 = r;
    end
  endtask

  task automatic clearModel();
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    popped[0]  = 0; popped[1]  = 0;
    sb0.delete();
    sb1.delete();
  endtask

  // The task samples on the falling edge, compares against the model and
  // advances the model with the handshakes predicted for the next rising
  // edge. It returns 1 time unit after that edge.
  task automatic checkOutput(input int sel, input string tag);
    logic        v, r, exp_irdy, exp_ovld, passthru, push, pop;
    logic [31:0] d, front, exp_outs;
    int          cnt;
    @(negedge clk);
    if (sel == 0) begin
      v = ins_valid0; r = outs_ready0; d = ins0;
      front = (sb0.size() > 0) ? sb0[0] : 32'h0;
    end else begin
      v = ins_valid1; r = outs_ready1; d = ins1;
      front = (sb1.size() > 0) ? sb1[0] : 32'h0;
    end
    cnt      = exp_cnt[sel];
    exp_irdy = (cnt < slots[sel]);
    exp_ovld = (cnt > 0);
    exp_outs = (cnt > 0) ? front : 32'h0;
    passthru = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    if (cnt == 0 && v) begin
      exp_ovld = 1'b1;
      exp_outs = d;
      passthru = r;
    end
`endif
    if (sel == 0) begin
      check({tag, ".ins_ready"},  {31'b0, ins_ready0},  {31'b0, exp_irdy});
      check({tag, ".outs_valid"}, {31'b0, outs_valid0}, {31'b0, exp_ovld});
      check({tag, ".outs"},       outs0,                exp_outs);
    end else begin
      check({tag, ".ins_ready"},  {31'b0, ins_ready1},  {31'b0, exp_irdy});
      check({tag, ".outs_valid"}, {31'b0, outs_valid1}, {31'b0, exp_ovld});
      check({tag, ".outs"},       outs1,                exp_outs);
    end
    push = v && exp_irdy && !passthru;
    pop  = r && (cnt > 0);
    if (passthru) popped[sel]++;
    if (pop) begin
      popped[sel]++;
      if (sel == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end
    if (push) begin
      if (sel == 0) sb0.push_back(d); else sb1.push_back(d);
    end
    exp_cnt[sel] = cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    slots[0] = 4;
    slots[1] = 3;
    clearModel();
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: empty, ready, zero payload.
    checkOutput(0, "reset_idle");
    checkOutput(1, "reset_idle3");

    // One word held while the consumer stalls.
    applyStimulus(0, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput(0, "beef_push");
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "beef_hold1");
    checkOutput(0, "beef_hold2");
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    checkOutput(0, "beef_pop");
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    checkOutput(0, "beef_empty");

    // Fill all four slots, then offer a fifth word while draining. The
    // fifth word must wait one cycle for ins_ready.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1'b1, 32'(i), 1'b0);
      checkOutput(0, "fill");
    end
    applyStimulus(0, 1'b1, 32'd5, 1'b0);
    checkOutput(0, "full_stall");
    applyStimulus(0, 1'b1, 32'd5, 1'b1);
    checkOutput(0, "full_pop_bubble");
    checkOutput(0, "accept_after_pop");
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) checkOutput(0, "drain");
    checkOutput(0, "drained");

    // Asynchronous reset with three words in flight.
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 32'hA0 + 32'(i), 1'b0);
      checkOutput(0, "pre_reset");
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    check("async_rst.outs_valid", {31'b0, outs_valid0}, 32'h0);
    check("async_rst.ins_ready",  {31'b0, ins_ready0},  32'h1);
    check("async_rst.outs",       outs0,                32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    clearModel();
    checkOutput(0, "post_reset");

    // Same-cycle forwarding on an empty buffer (transparent build only).
    // The opaque build must instead show the word one cycle later.
    applyStimulus(0, 1'b1, 32'h12345678, 1'b1);
    checkOutput(0, "bypass_offer");
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    checkOutput(0, "bypass_after");
    checkOutput(0, "bypass_idle");

    // Continuous stream of 0..99 with an always-ready consumer.
    popped[0] = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1'b1, 32'(i), 1'b1);
      checkOutput(0, "stream");
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b1);
    checkOutput(0, "stream_tail");
    check("stream_words_out", 32'(popped[0]), 32'd100);
    checkOutput(0, "stream_idle");

    // Random valid/ready on the 3-slot instance, with the producer
    // holding its word until it is accepted.
    next_word = 32'h1000;
    pend      = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rv = pend ? 1'b1 : 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      applyStimulus(1, rv, next_word, rr);
      accepted = rv && (exp_cnt[1] < slots[1]);
      checkOutput(1, "rand3");
      if (accepted) begin
        next_word = next_word + 32'd1;
        pend = 1'b0;
      end else begin
        pend = rv;
      end
    end
    applyStimulus(1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) checkOutput(1, "rand3_drain");
    checkOutput(1, "rand3_empty");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
